// File: rtl/uart_tx_cfg_if.sv
// AXI4-Stream byte handshake between a word source and the UART transmitter.
interface uart_tx_cfg_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_tx_cfg.sv
// UART transmitter with runtime parity/stop selection; bit period is 8 x prescale clocks.
// One word per accepted AXI-Stream beat, LSB first, all outputs registered.
module uart_tx_cfg #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  uart_tx_cfg_if.slave              s_axis,
  output logic                      txd,
  output logic                      busy,
  output logic                      tx_done,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [1:0]                parity_mode,
  input  logic                      stop_bits
);

  localparam int unsigned CntW    = PRESCALE_WIDTH + 3;
  localparam int unsigned BitCntW = $clog2(DATA_WIDTH);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                    state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [BitCntW-1:0]        bit_q, bit_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic                      par_en_q, par_en_d;
  logic                      par_q, par_d;
  logic                      stop2_q, stop2_d;
  logic                      tready_q, tready_d;
  logic                      txd_q, txd_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic                      accept;
  logic                      tick;
  logic [PRESCALE_WIDTH-1:0] presc_m1;
  logic [CntW-1:0]           reload;

  // Period reload is 8*max(p,1)-1 == {max(p,1)-1, 3'b111}; presc_q holds the clamped p-1.
  assign presc_m1 = (prescale == '0) ? '0 : prescale - PRESCALE_WIDTH'(1);
  assign reload   = {presc_q, 3'b111};
  assign tick     = (cnt_q == '0);
  assign accept   = (state_q == StIdle) && tready_q && s_axis.tvalid;

  always_comb begin
    state_d  = state_q;
    cnt_d    = tick ? cnt_q : cnt_q - CntW'(1);
    bit_d    = bit_q;
    data_d   = data_q;
    presc_d  = presc_q;
    par_en_d = par_en_q;
    par_d    = par_q;
    stop2_d  = stop2_q;
    tready_d = tready_q;
    txd_d    = txd_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        tready_d = 1'b1;
        txd_d    = 1'b1;
        busy_d   = 1'b0;
        cnt_d    = '0;
        if (accept) begin
          data_d   = s_axis.tdata;
          presc_d  = presc_m1;
          par_en_d = (parity_mode == 2'd1) || (parity_mode == 2'd2);
          par_d    = (^s_axis.tdata) ^ (parity_mode == 2'd2);
          stop2_d  = stop_bits;
          cnt_d    = {presc_m1, 3'b111};
          bit_d    = '0;
          state_d  = StStart;
          tready_d = 1'b0;
          busy_d   = 1'b1;
          txd_d    = 1'b0;
        end
      end
      StStart: begin
        if (tick) begin
          state_d = StData;
          txd_d   = data_q[0];
          data_d  = data_q >> 1;
          bit_d   = '0;
          cnt_d   = reload;
        end
      end
      StData: begin
        if (tick) begin
          cnt_d = reload;
          if (bit_q == LastBit) begin
            if (par_en_q) begin
              state_d = StParity;
              txd_d   = par_q;
            end else begin
              state_d = StStop;
              txd_d   = 1'b1;
              bit_d   = '0;
            end
          end else begin
            bit_d  = bit_q + BitCntW'(1);
            txd_d  = data_q[0];
            data_d = data_q >> 1;
          end
        end
      end
      StParity: begin
        if (tick) begin
          state_d = StStop;
          txd_d   = 1'b1;
          bit_d   = '0;
          cnt_d   = reload;
        end
      end
      StStop: begin
        if (tick) begin
          // bit_q doubles as the stop-bit index so two-stop frames reuse the same counter.
          if (stop2_q && (bit_q == '0)) begin
            bit_d = BitCntW'(1);
            cnt_d = reload;
          end else begin
            state_d  = StIdle;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            tready_d = 1'b1;
            txd_d    = 1'b1;
            bit_d    = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bit_q    <= '0;
      data_q   <= '0;
      presc_q  <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      stop2_q  <= 1'b0;
      tready_q <= 1'b0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      presc_q  <= presc_d;
      par_en_q <= par_en_d;
      par_q    <= par_d;
      stop2_q  <= stop2_d;
      tready_q <= tready_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign s_axis.tready = tready_q;
  assign txd           = txd_q;
  assign busy          = busy_q;
  assign tx_done       = done_q;

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised AXI4-Stream UART transmitter, successor to the fixed 8N1 transmitter in the uart-no-param design. It serialises one DATA_WIDTH word per accepted beat onto txd, LSB first. Parity (none/even/odd) and stop-bit count (1 or 2) are selected at runtime. Timing uses the existing prescale convention: one bit period is 8 x prescale clocks. It sits between the AXI-Stream source and the pad, beside the matching receiver.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..9.
PRESCALE_WIDTH, 16, width of the prescale input.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst_n  input  1  synchronous reset, active-low.
s_axis_tdata  input  DATA_WIDTH  word to transmit.
s_axis_tvalid  input  1  source has a word.
s_axis_tready  output  1  block can accept a word this cycle.
txd  output  1  serial line; idles high.
busy  output  1  frame in progress.
tx_done  output  1  one-cycle pulse at the end of the last stop bit.
prescale  input  PRESCALE_WIDTH  bit period = 8 x prescale clocks; a value of 0 is treated as 1.
parity_mode  input  2  0 = none, 1 = even, 2 = odd, 3 = none (reserved).
stop_bits  input  1  0 = one stop bit, 1 = two stop bits.

Behaviour:
- All outputs are registered.
- Reset state (rst_n = 0 at a clock edge): s_axis_tready = 0, txd = 1, busy = 0, tx_done = 0, FSM in IDLE, all counters cleared. Reset wins over every other event.
- Reset mid-frame aborts the frame. txd returns high at that edge and the partial word is discarded.
- After reset releases, s_axis_tready rises at the first edge with rst_n = 1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: s_axis_tready = 1, txd = 1. A transfer occurs when s_axis_tvalid and s_axis_tready are both high at an edge. At that edge the block:
  - latches tdata, prescale, parity_mode and stop_bits; later changes to these inputs have no effect until the next acceptance;
  - moves to START and drives s_axis_tready = 0, busy = 1, txd = 0.
- Latency: txd falls in the cycle immediately after the accept edge.
- Bit timing: a period counter of PRESCALE_WIDTH+3 bits loads 8 x max(prescale, 1) - 1 and decrements to 0. Each bit is held for exactly 8 x max(prescale, 1) cycles.
- START: one bit period of 0, then DATA.
- DATA: DATA_WIDTH bit periods, shifting LSB first. A bit counter of clog2(DATA_WIDTH) bits counts the data bits. On completion the FSM goes to PARITY if parity is enabled, otherwise to STOP.
- PARITY: one bit period.
  - Even mode: XOR of the data bits.
  - Odd mode: inverted XOR of the data bits.
- STOP: txd = 1 for 1 or 2 bit periods. On the final edge of the last period the FSM returns to IDLE and drives busy = 0, tx_done = 1 for one cycle, s_axis_tready = 1.
- Frame length: (1 + DATA_WIDTH + P + S) x 8 x max(prescale, 1) cycles, where P is 0 or 1 and S is 1 or 2.
- Back-to-back frames: with tvalid held high, the next word is accepted in the first IDLE cycle. Start bits are therefore frame length + 1 cycles apart, and txd stays 1 during that extra cycle.
- s_axis_tready is never high while busy = 1. tvalid is ignored outside IDLE.
- tdata is captured only at acceptance. The source may change it freely afterwards.

Test Plan:
- DATA_WIDTH=8, prescale=1, parity 0, stop 0, send 0xA5. Required: txd = 0,1,0,1,0,0,1,0,1,1, each bit 8 cycles, total 80 cycles. tx_done pulses in cycle 80 after acceptance; tready is back high in the same cycle.
- Same word with parity 1 (even): parity bit = 0, frame 88 cycles. With parity 2 (odd): parity bit = 1.
- 0x3C, parity 2, stop_bits 1, prescale=2. Required: 12 bits x 16 = 192 cycles; parity bit 1; txd high for the final 32 cycles.
- Two words 0x01 then 0xFF with tvalid held high, prescale=1, 8N1. Required: start bits 81 cycles apart and exactly two accept handshakes. Additionally, change prescale to 4 during frame 1: frame 1 timing is unchanged and frame 2 uses 32-cycle bits.
- Assert rst_n = 0 during data bit 3. Required: next edge gives txd = 1, busy = 0, tready = 0 and no tx_done. The first cycle after release gives tready = 1, and a new frame then transmits correctly.
- prescale = 0 -> bits are 8 cycles wide, identical to prescale = 1. DATA_WIDTH=5 build: 0x15 with 8N1 gives a 56-cycle frame.
